// File: rtl/mem_ctrl_pkg.sv
// Shared configuration for the memory controller and the instruction cache:
// FSM encoding, IO boundary and load/store length codes.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IREAD,
        DREAD,
        DWRITE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_INSTR,
        SRC_LOAD,
        SRC_STORE
    } src_t;

    localparam logic [31:0] IO_BOUND_DEFAULT = 32'h0003_0000;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    // The illegal length code is treated as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating between instruction fetches and
// load/store requests, with UART back-pressure and pipeline flush support.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BOUND = IO_BOUND_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        instr_in_enable,
    input  logic [31:0] instr_in_addr,
    output logic        instr_in_valid,
    output logic [31:0] instr_in,
    input  logic        lsb_enable,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_valid,
    output logic [31:0] lsb_rdata,
    input  logic        flush
);

    state_t      state, state_nx;
    src_t        src;
    logic [2:0]  cnt, cnt_nx, nbytes;
    logic [31:0] addr, wdata, data_buf, instr_hold, rdata_hold, addr_k;
    logic [1:0]  cap_idx;
    logic        latch_lsb, latch_instr, capture, commit, io_stall;

    assign addr_k   = addr + {29'd0, cnt};
    assign cap_idx  = cnt[1:0] - 2'd1;
    assign io_stall = (addr >= IO_BOUND) && io_buffer_full;

    // While rdy is low a read re-presents the previous byte address, so the
    // RAM keeps returning the byte that is still waiting to be captured.
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        latch_lsb      = 1'b0;
        latch_instr    = 1'b0;
        capture        = 1'b0;
        commit         = 1'b0;
        mem_a          = 32'd0;
        mem_dout       = 8'd0;
        mem_wr         = 1'b0;
        instr_in_valid = 1'b0;
        lsb_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (lsb_enable) begin
                    latch_lsb = 1'b1;
                    state_nx  = lsb_wr ? DWRITE : DREAD;
                    cnt_nx    = 3'd0;
                end else if (instr_in_enable && !flush) begin
                    latch_instr = 1'b1;
                    state_nx    = IREAD;
                    cnt_nx      = 3'd0;
                end
            end
            IREAD, DREAD: begin
                if (!rdy && cnt != 3'd0)
                    mem_a = addr_k - 32'd1;
                else if (cnt != nbytes)
                    mem_a = addr_k;
                if (state == IREAD && flush) begin
                    state_nx = IDLE;
                    cnt_nx   = 3'd0;
                end else begin
                    capture = (cnt != 3'd0);
                    if (cnt == nbytes)
                        state_nx = DONE;
                    else
                        cnt_nx = cnt + 3'd1;
                end
            end
            DWRITE: begin
                mem_a    = addr_k;
                mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                if (!io_stall) begin
                    mem_wr = rdy;
                    if (cnt == nbytes - 3'd1)
                        state_nx = DONE;
                    else
                        cnt_nx = cnt + 3'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
                if (src == SRC_INSTR) begin
                    instr_in_valid = rdy && !flush;
                    commit         = !flush;
                end else begin
                    lsb_valid = rdy;
                    commit    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (rdy) begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request latch, byte assembly and the held results seen between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src        <= SRC_INSTR;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            nbytes     <= 3'd0;
            data_buf   <= 32'd0;
            instr_hold <= 32'd0;
            rdata_hold <= 32'd0;
        end else if (rdy) begin
            if (latch_lsb) begin
                src      <= lsb_wr ? SRC_STORE : SRC_LOAD;
                addr     <= lsb_addr;
                wdata    <= lsb_wdata;
                nbytes   <= (!lsb_wr && lsb_addr >= IO_BOUND) ? 3'd1 : len_bytes(lsb_len);
                data_buf <= 32'd0;
            end else if (latch_instr) begin
                src      <= SRC_INSTR;
                addr     <= instr_in_addr;
                wdata    <= 32'd0;
                nbytes   <= 3'd4;
                data_buf <= 32'd0;
            end
            if (capture)
                data_buf[{cap_idx, 3'b000} +: 8] <= mem_din;
            if (commit) begin
                if (src == SRC_INSTR)
                    instr_hold <= data_buf;
                else if (src == SRC_LOAD)
                    rdata_hold <= data_buf;
            end
        end
    end

    assign instr_in  = (state == DONE && src == SRC_INSTR) ? data_buf : instr_hold;
    assign lsb_rdata = (state == DONE && src == SRC_LOAD)  ? data_buf : rdata_hold;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of load/store vectors plus
// hand-written fetch, arbitration, flush and reset sequences.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rdy, io_buffer_full, ram_init;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        instr_in_enable, instr_in_valid;
    logic [31:0] instr_in_addr, instr_in;
    logic        lsb_enable, lsb_wr, lsb_valid, flush;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_len;

    logic [7:0]  ram [0:4095];
    logic [7:0]  io_log [$];

    int checks = 0;
    int fails  = 0;

    mem_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdy             (rdy),
        .io_buffer_full  (io_buffer_full),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_a           (mem_a),
        .mem_wr          (mem_wr),
        .instr_in_enable (instr_in_enable),
        .instr_in_addr   (instr_in_addr),
        .instr_in_valid  (instr_in_valid),
        .instr_in        (instr_in),
        .lsb_enable      (lsb_enable),
        .lsb_wr          (lsb_wr),
        .lsb_addr        (lsb_addr),
        .lsb_len         (lsb_len),
        .lsb_wdata       (lsb_wdata),
        .lsb_valid       (lsb_valid),
        .lsb_rdata       (lsb_rdata),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read; writes at or above the IO boundary go to the UART log.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h004] <= 8'h99;
            ram[12'h010] <= 8'h34;
            ram[12'h011] <= 8'h12;
            ram[12'h012] <= 8'hAB;
            ram[12'h100] <= 8'h13;
            ram[12'h101] <= 8'h05;
        end else if (mem_wr) begin
            if (mem_a >= 32'h0003_0000)
                io_log.push_back(mem_dout);
            else
                ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        int          rs, rl;
        int          fs, fl;
        int          xs, xl;
        int          exp_cyc;
        logic [31:0] exp_rd;
        int          exp_wrs;
    } vec_t;

    vec_t vecs [13];

    function automatic bit inwin(input int c, input int s, input int l);
        return (l > 0) && (c >= s) && (c < s + l);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One load/store; cycle 0 is the IDLE cycle whose closing edge samples the request.
    task automatic applyStimulus(input vec_t v, output int vcyc, output logic [31:0] rd, output int wrs);
        int cyc;
        @(posedge clk); #1;
        lsb_enable = 1'b1;
        lsb_wr     = v.wr;
        lsb_addr   = v.addr;
        lsb_len    = v.len;
        lsb_wdata  = v.wdata;
        cyc = 0;
        rdy            = !inwin(0, v.rs, v.rl);
        io_buffer_full = inwin(0, v.fs, v.fl);
        flush          = inwin(0, v.xs, v.xl);
        vcyc = -1; rd = 32'd0; wrs = 0;
        while (vcyc < 0 && cyc < 40) begin
            @(posedge clk); cyc++; #1;
            rdy            = !inwin(cyc, v.rs, v.rl);
            io_buffer_full = inwin(cyc, v.fs, v.fl);
            flush          = inwin(cyc, v.xs, v.xl);
            @(negedge clk);
            if (mem_wr) wrs++;
            if (lsb_valid) begin
                vcyc = cyc;
                rd   = lsb_rdata;
                lsb_enable = 1'b0;
            end
        end
        rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0; lsb_enable = 1'b0;
    endtask

    task automatic runFetch(input string tag, input logic [31:0] a, input int xs, input int xl,
                            input bit drop, input bit chk_addr, output int vcyc);
        int cyc;
        @(posedge clk); #1;
        instr_in_enable = 1'b1;
        instr_in_addr   = a;
        cyc  = 0;
        flush = inwin(0, xs, xl);
        vcyc = -1;
        while (cyc < 12) begin
            @(posedge clk); cyc++; #1;
            flush = inwin(cyc, xs, xl);
            if (drop && cyc == xs) instr_in_enable = 1'b0;
            @(negedge clk);
            if (chk_addr && cyc >= 1 && cyc <= 4) begin
                checkOutput($sformatf("%s_mem_a_c%0d", tag, cyc), mem_a, a + 32'(cyc - 1));
                checkOutput($sformatf("%s_mem_wr_c%0d", tag, cyc), {31'd0, mem_wr}, 32'd0);
            end
            if (drop && cyc == xs + 1)
                checkOutput($sformatf("%s_idle_mem_a", tag), mem_a, 32'd0);
            if (instr_in_valid && vcyc < 0) begin
                vcyc = cyc;
                instr_in_enable = 1'b0;
            end
        end
        flush = 1'b0; instr_in_enable = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          vc, wc, lv, iv, cyc;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 32'h0000_0200, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 5, 32'h0,         4};
        vecs[1]  = '{1'b0, 32'h0000_0200, 2'd2, 32'h0,         0, 0, 0, 0, 0, 0, 6, 32'hDEAD_BEEF, 0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 2'd1, 32'h0,         0, 0, 0, 0, 0, 0, 4, 32'h0000_1234, 0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 2'd1, 32'h0,         2, 2, 0, 0, 0, 0, 6, 32'h0000_1234, 0};
        vecs[4]  = '{1'b0, 32'h0000_0012, 2'd0, 32'h0,         0, 0, 0, 0, 1, 3, 3, 32'h0000_00AB, 0};
        vecs[5]  = '{1'b1, 32'h0000_0201, 2'd0, 32'h0000_005A, 0, 0, 0, 0, 0, 0, 2, 32'h0,         1};
        vecs[6]  = '{1'b0, 32'h0000_0200, 2'd2, 32'h0,         0, 0, 0, 0, 0, 0, 6, 32'hDEAD_5AEF, 0};
        vecs[7]  = '{1'b1, 32'h0000_0202, 2'd1, 32'hCAFE_1357, 0, 0, 0, 0, 0, 0, 3, 32'h0,         2};
        vecs[8]  = '{1'b0, 32'h0000_0200, 2'd2, 32'h0,         0, 0, 0, 0, 0, 0, 6, 32'h1357_5AEF, 0};
        vecs[9]  = '{1'b1, 32'h0003_0000, 2'd0, 32'h0000_0041, 0, 0, 1, 3, 0, 0, 5, 32'h0,         1};
        vecs[10] = '{1'b0, 32'h0003_0004, 2'd2, 32'h0,         0, 0, 0, 0, 0, 0, 3, 32'h0000_0099, 0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF, 2'd1, 32'h0000_7788, 0, 0, 0, 0, 0, 0, 3, 32'h0,         2};
        vecs[12] = '{1'b0, 32'h0000_0000, 2'd0, 32'h0,         0, 0, 0, 0, 0, 0, 3, 32'h0000_0077, 0};

        rst_n = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; ram_init = 1'b1; flush = 1'b0;
        instr_in_enable = 1'b0; instr_in_addr = 32'd0;
        lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_len = 2'd0; lsb_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mem_a",     mem_a, 32'd0);
        checkOutput("reset_mem_wr",    {31'd0, mem_wr}, 32'd0);
        checkOutput("reset_lsb_rdata", lsb_rdata, 32'd0);
        checkOutput("reset_instr_in",  instr_in, 32'd0);
        rst_n = 1'b1; ram_init = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], vc, rd, wc);
            checkOutput($sformatf("vec%0d_valid_cycle", i), 32'(vc), 32'(vecs[i].exp_cyc));
            checkOutput($sformatf("vec%0d_write_count", i), 32'(wc), 32'(vecs[i].exp_wrs));
            if (!vecs[i].wr)
                checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end
        checkOutput("io_log_size",  32'(io_log.size()), 32'd2);
        if (io_log.size() == 2) begin
            checkOutput("io_log_0", {24'd0, io_log[0]}, 32'h41);
            checkOutput("io_log_1", {24'd0, io_log[1]}, 32'h88);
        end

        runFetch("fetch", 32'h0000_0100, 0, 0, 1'b0, 1'b1, vc);
        checkOutput("fetch_valid_cycle", 32'(vc), 32'd6);
        checkOutput("fetch_instr", instr_in, 32'h0000_0513);

        @(posedge clk); #1;
        lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h12; lsb_len = 2'd0;
        instr_in_enable = 1'b1; instr_in_addr = 32'h0000_0010;
        cyc = 0; lv = -1; iv = -1;
        while (cyc < 14) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (lsb_valid && lv < 0) begin lv = cyc; lsb_enable = 1'b0; end
            if (instr_in_valid && iv < 0) begin
                iv = cyc;
                checkOutput("arb_instr", instr_in, 32'h0000_AB12_34 & 32'h00AB_1234);
                instr_in_enable = 1'b0;
            end
        end
        checkOutput("arb_lsb_cycle",   32'(lv), 32'd3);
        checkOutput("arb_fetch_cycle", 32'(iv), 32'd10);
        checkOutput("arb_lsb_rdata",   lsb_rdata, 32'h0000_00AB);

        runFetch("flush_iread", 32'h0000_0100, 3, 1, 1'b1, 1'b0, vc);
        checkOutput("flush_no_valid", 32'(vc), 32'hFFFF_FFFF);
        checkOutput("flush_instr_held", instr_in, 32'h00AB_1234);
        checkOutput("flush_rdata_held", lsb_rdata, 32'h0000_00AB);

        runFetch("flush_idle", 32'h0000_0100, 0, 1, 1'b0, 1'b0, vc);
        checkOutput("flush_idle_valid_cycle", 32'(vc), 32'd7);
        checkOutput("flush_idle_instr", instr_in, 32'h0000_0513);

        @(posedge clk); #1;
        lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 2'd2;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("midload_mem_a", mem_a, 32'h0000_0202);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_a",          mem_a, 32'd0);
        checkOutput("rst_mem_wr",         {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_mem_dout",       {24'd0, mem_dout}, 32'd0);
        checkOutput("rst_instr_in",       instr_in, 32'd0);
        checkOutput("rst_lsb_rdata",      lsb_rdata, 32'd0);
        checkOutput("rst_lsb_valid",      {31'd0, lsb_valid}, 32'd0);
        checkOutput("rst_instr_in_valid", {31'd0, instr_in_valid}, 32'd0);
        lsb_enable = 1'b0;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
